// File: rtl/square_freq_decoder.sv
// square_freq_decoder: measures an incoming square wave against clk and
// recovers the VCO (range, control_frequency) setting that would produce it.
// Ports: clk, rst (async, active-high), square_wave (async input);
//   range/control_frequency (decoded setting), period_cycles (last period),
//   meas_valid/meas_error (result pulses), duty_ok, locked, no_signal.
module square_freq_decoder #(
    parameter int CNT_W   = 21,
    parameter int BASE_K  = 100,
    parameter int BASE_H  = 100000,
    parameter int TOL_K   = 2,
    parameter int TOL_H   = 200,
    parameter int LOCK_N  = 3,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             square_wave,
    output logic             range,
    output logic [2:0]       control_frequency,
    output logic [CNT_W-1:0] period_cycles,
    output logic             meas_valid,
    output logic             meas_error,
    output logic             duty_ok,
    output logic             locked,
    output logic             no_signal
);
    localparam int W  = CNT_W + 1;
    localparam int RW = $clog2(LOCK_N + 1);

    localparam logic [W-1:0]     BK     = W'(BASE_K);
    localparam logic [W-1:0]     BH     = W'(BASE_H);
    localparam logic [W-1:0]     TK     = W'(TOL_K);
    localparam logic [W-1:0]     TH     = W'(TOL_H);
    localparam logic [W-1:0]     TK2    = W'(2 * TOL_K);
    localparam logic [W-1:0]     TH2    = W'(2 * TOL_H);
    localparam logic [W-1:0]     GLITCH = W'(BASE_K - TOL_K);
    localparam logic [W-1:0]     TMO    = W'(TIMEOUT);
    localparam logic [CNT_W-1:0] SAT    = '1;
    localparam logic [RW-1:0]    LOCK   = RW'(LOCK_N);

    typedef enum logic [1:0] {IDLE, MEASURE, CLASSIFY} state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]   per_q, per_d;
    logic [CNT_W-1:0]   hi_q, hi_d;
    logic [CNT_W-1:0]   p_q, p_d;
    logic [CNT_W-1:0]   h_q, h_d;
    logic [W-1:0]       tgt_q, tgt_d;
    logic [2:0]         idx_q, idx_d;
    logic               band_q, band_d;
    logic               range_q, range_d;
    logic [2:0]         cf_q, cf_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               valid_q, valid_d;
    logic               error_q, error_d;
    logic               duty_q, duty_d;
    logic               locked_q, locked_d;
    logic               nosig_q, nosig_d;
    logic [RW-1:0]      run_q, run_d;

    logic               rise;
    logic               hit;
    logic               same;
    logic [W-1:0]       p_w;
    logic [W-1:0]       h2_w;
    logic [W-1:0]       diff;
    logic [W-1:0]       dty;
    logic [RW-1:0]      run_n;

    // Metastability synchronizer plus one extra stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= square_wave;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Classification datapath; widened by one bit so 2H cannot overflow.
    always_comb begin
        rise  = s2_q & ~s3_q;
        p_w   = {1'b0, p_q};
        h2_w  = {h_q, 1'b0};
        diff  = (p_w >= tgt_q) ? p_w - tgt_q : tgt_q - p_w;
        dty   = (h2_w >= p_w) ? h2_w - p_w : p_w - h2_w;
        hit   = diff <= (band_q ? TH : TK);
        same  = (run_q != '0) && (band_q == range_q) && (idx_q == cf_q);
        run_n = same ? ((run_q >= LOCK) ? run_q : run_q + RW'(1)) : RW'(1);
    end

    always_comb begin
        state_d  = state_q;
        per_d    = (per_q == SAT) ? per_q : per_q + CNT_W'(1);
        hi_d     = (s2_q && hi_q != SAT) ? hi_q + CNT_W'(1) : hi_q;
        p_d      = p_q;
        h_d      = h_q;
        tgt_d    = tgt_q;
        idx_d    = idx_q;
        band_d   = band_q;
        range_d  = range_q;
        cf_d     = cf_q;
        period_d = period_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        duty_d   = duty_q;
        locked_d = locked_q;
        nosig_d  = nosig_q;
        run_d    = run_q;

        if (rise) begin
            per_d = CNT_W'(1);
            hi_d  = '0;
            if (state_q == IDLE) begin
                // First edge only opens a period; nothing to report yet.
                nosig_d = 1'b0;
                state_d = MEASURE;
            end else begin
                // A rise during CLASSIFY abandons the older search.
                p_d      = per_q;
                h_d      = hi_q;
                period_d = per_q;
                if ({1'b0, per_q} < GLITCH) begin
                    error_d  = 1'b1;
                    locked_d = 1'b0;
                    run_d    = '0;
                    state_d  = MEASURE;
                end else begin
                    tgt_d   = BK;
                    band_d  = 1'b0;
                    idx_d   = 3'd0;
                    state_d = CLASSIFY;
                end
            end
        end else begin
            case (state_q)
                IDLE, MEASURE: begin
                    if ({1'b0, per_q} >= TMO) begin
                        nosig_d  = 1'b1;
                        locked_d = 1'b0;
                        run_d    = '0;
                        state_d  = IDLE;
                    end
                end
                CLASSIFY: begin
                    if (hit) begin
                        range_d  = band_q;
                        cf_d     = idx_q;
                        valid_d  = 1'b1;
                        duty_d   = dty <= (band_q ? TH2 : TK2);
                        run_d    = run_n;
                        locked_d = run_n >= LOCK;
                        state_d  = MEASURE;
                    end else if (idx_q == 3'd7) begin
                        if (!band_q) begin
                            band_d = 1'b1;
                            idx_d  = 3'd0;
                            tgt_d  = BH;
                        end else begin
                            error_d  = 1'b1;
                            locked_d = 1'b0;
                            duty_d   = 1'b0;
                            run_d    = '0;
                            state_d  = MEASURE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tgt_d = tgt_q + (band_q ? BH : BK);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            per_q    <= '0;
            hi_q     <= '0;
            p_q      <= '0;
            h_q      <= '0;
            tgt_q    <= '0;
            idx_q    <= '0;
            band_q   <= 1'b0;
            range_q  <= 1'b0;
            cf_q     <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            duty_q   <= 1'b0;
            locked_q <= 1'b0;
            nosig_q  <= 1'b0;
            run_q    <= '0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            hi_q     <= hi_d;
            p_q      <= p_d;
            h_q      <= h_d;
            tgt_q    <= tgt_d;
            idx_q    <= idx_d;
            band_q   <= band_d;
            range_q  <= range_d;
            cf_q     <= cf_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            duty_q   <= duty_d;
            locked_q <= locked_d;
            nosig_q  <= nosig_d;
            run_q    <= run_d;
        end
    end

    assign range             = range_q;
    assign control_frequency = cf_q;
    assign period_cycles     = period_q;
    assign meas_valid        = valid_q;
    assign meas_error        = error_q;
    assign duty_ok           = duty_q;
    assign locked            = locked_q;
    assign no_signal         = nosig_q;

endmodule
